// File: rtl/dm_wbuf_if.sv
// ---------------------------------------------------------------------------
// dm_wbuf_if -- bundle of every non-clock signal of the data-memory store
// buffer.
//
// The buffer itself takes the slave modport. The surrounding logic takes the
// master modport; that is the byte-lane controller together with the data
// memory.
//
// Signal groups:
//   wr_*        store request from the byte-lane controller, plus wr_ready
//   mem_*       head entry presented to data memory, plus mem_ack
//   rd_addr     load address used for store-to-load forwarding
//   rd_data_mem raw word read from memory
//   rd_data     the merged word returned to the controller
//   empty/count occupancy status
// ---------------------------------------------------------------------------
interface dm_wbuf_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          wr_valid;
  logic [31:0]   wr_addr;
  logic [31:0]   wr_data;
  logic [3:0]    wr_wea;
  logic          wr_ready;

  logic          mem_req;
  logic [31:0]   mem_addr;
  logic [31:0]   mem_wdata;
  logic [3:0]    mem_wea;
  logic          mem_ack;

  logic [31:0]   rd_addr;
  logic [31:0]   rd_data_mem;
  logic [31:0]   rd_data;

  logic          empty;
  logic [CW-1:0] count;

  // View from inside the store buffer
  modport slave (
    input  wr_valid, wr_addr, wr_data, wr_wea, mem_ack, rd_addr, rd_data_mem,
    output wr_ready, mem_req, mem_addr, mem_wdata, mem_wea, rd_data, empty, count
  );

  // View from the controller / memory side
  modport master (
    output wr_valid, wr_addr, wr_data, wr_wea, mem_ack, rd_addr, rd_data_mem,
    input  wr_ready, mem_req, mem_addr, mem_wdata, mem_wea, rd_data, empty, count
  );
endinterface

// File: rtl/dm_wbuf.sv
// ---------------------------------------------------------------------------
// dm_wbuf -- in-order store (write) buffer in front of the data memory.
//
// Stores are queued in a circular FIFO and drained one entry per mem_ack, in
// program order. Loads see buffered bytes through lane-wise forwarding,
// merged over the raw memory word. When several entries match, the youngest
// matching entry wins each lane.
//
// Ports:
//   clk  sole clock, rising edge
//   rst  synchronous, active-high; empties the buffer
//   bus  dm_wbuf_if.slave
//          wr_*   store in
//          mem_*  store drain out
//          rd_*   forwarding
//          empty, count  occupancy
// ---------------------------------------------------------------------------
module dm_wbuf #(
  parameter int DEPTH = 4
) (
  input logic      clk,
  input logic      rst,
  dm_wbuf_if.slave bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef logic [PW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  // Entry storage is deliberately left without reset.
  // Validity comes only from head/count, so stale contents are never seen.
  logic [29:0] ent_addr [DEPTH];
  logic [31:0] ent_data [DEPTH];
  logic [3:0]  ent_wea  [DEPTH];

  ptr_t        head;
  ptr_t        tail;
  cnt_t        count_q;

  logic        empty_w;
  logic        full_w;
  logic        push;
  logic        pop;
  ptr_t        fwd_idx;
  logic [31:0] rd_merge;

  // The two address LSBs are don't-care for word-granular matching
  logic        unused_addr_bits;
  assign unused_addr_bits = ^{bus.wr_addr[1:0], bus.rd_addr[1:0]};

  // Handshake decisions come from registered occupancy only.
  // As a result wr_ready never combinationally depends on mem_ack.
  // A store with no byte enables is a no-op and is not queued.
  assign empty_w = (count_q == '0);
  assign full_w  = (count_q == cnt_t'(DEPTH));
  assign push    = bus.wr_valid && !full_w && (bus.wr_wea != 4'b0000);
  assign pop     = !empty_w && bus.mem_ack;

  // Pointer and occupancy register.
  // DEPTH is a power of two, so the pointers wrap naturally at their width.
  // Simultaneous push and pop move both pointers and leave count alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
    end else begin
      if (push) tail <= tail + ptr_t'(1);
      if (pop)  head <= head + ptr_t'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + cnt_t'(1);
        2'b01:   count_q <= count_q - cnt_t'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Entry write port: the accepted store lands at the tail slot
  always_ff @(posedge clk) begin
    if (push) begin
      ent_addr[tail] <= bus.wr_addr[31:2];
      ent_data[tail] <= bus.wr_data;
      ent_wea[tail]  <= bus.wr_wea;
    end
  end

  // Store-to-load forwarding.
  // Entries are walked from oldest (head) to youngest, and a later match
  // simply overwrites an earlier one. That gives "youngest wins" per lane
  // without a priority encoder.
  // The entry being popped this cycle is still inside count, so it
  // forwards. A store being pushed this cycle is not yet stored, so it
  // does not.
  always_comb begin
    rd_merge = bus.rd_data_mem;
    fwd_idx  = head;
    for (int k = 0; k < DEPTH; k++) begin
      fwd_idx = head + ptr_t'(k);
      if ((cnt_t'(k) < count_q) && (ent_addr[fwd_idx] == bus.rd_addr[31:2])) begin
        for (int i = 0; i < 4; i++) begin
          if (ent_wea[fwd_idx][i]) rd_merge[8*i +: 8] = ent_data[fwd_idx][8*i +: 8];
        end
      end
    end
  end

  // Head entry drives the memory side directly.
  // Byte enables are forced to zero while nothing is queued.
  assign bus.mem_req   = !empty_w;
  assign bus.mem_addr  = {ent_addr[head], 2'b00};
  assign bus.mem_wdata = ent_data[head];
  assign bus.mem_wea   = empty_w ? 4'b0000 : ent_wea[head];

  assign bus.wr_ready  = !full_w;
  assign bus.rd_data   = rd_merge;
  assign bus.empty     = empty_w;
  assign bus.count     = count_q;

endmodule

// File: tb/tb_dm_wbuf.sv
// ---------------------------------------------------------------------------
// tb_dm_wbuf -- directed self-checking bench for dm_wbuf (DEPTH = 4).
//
// Inputs change 1 time unit after a rising edge. Outputs are sampled at
// that same offset, well away from the next edge.
// ---------------------------------------------------------------------------
module tb_dm_wbuf;

  logic clk;
  logic rst;

  int vectors;
  int miscompares;

  dm_wbuf_if #(.DEPTH(4)) bus ();

  dm_wbuf #(.DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Free-running clock, period 10
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compare one observed value against its hand-computed expectation
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock edge and settle just after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Set the store and ack inputs for the coming edge
  task automatic applyStimulus(input logic v, input logic [31:0] a, input logic [31:0] d,
                               input logic [3:0] w, input logic ack);
    bus.wr_valid = v;
    bus.wr_addr  = a;
    bus.wr_data  = d;
    bus.wr_wea   = w;
    bus.mem_ack  = ack;
  endtask

  // Single store attempt with no memory acknowledge
  task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w);
    applyStimulus(1'b1, a, d, w, 1'b0);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
  endtask

  // One-cycle memory acknowledge
  task automatic ack_once();
    applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
  endtask

  logic [31:0] exp_head [6];

  initial begin
    vectors     = 0;
    miscompares = 0;
    exp_head    = '{32'h0000_00BB, 32'h0000_00CC, 32'h0000_1000,
                    32'h0000_1001, 32'h0000_1002, 32'h0000_1003};
    applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    bus.rd_addr     = 32'h0000_0500;
    bus.rd_data_mem = 32'hDEAD_BEEF;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;

    // Reset state
    checkOutput("rst_empty",    32'(bus.empty),    32'd1);
    checkOutput("rst_wr_ready", 32'(bus.wr_ready), 32'd1);
    checkOutput("rst_mem_req",  32'(bus.mem_req),  32'd0);
    checkOutput("rst_mem_wea",  32'(bus.mem_wea),  32'd0);
    checkOutput("rst_count",    32'(bus.count),    32'd0);
    checkOutput("rst_rd_data",  bus.rd_data,       32'hDEAD_BEEF);

    // Single push, then drain
    push(32'h0000_0100, 32'h0000_00AB, 4'b0001);
    checkOutput("p1_mem_req",   32'(bus.mem_req),  32'd1);
    checkOutput("p1_mem_addr",  bus.mem_addr,      32'h0000_0100);
    checkOutput("p1_mem_wdata", bus.mem_wdata,     32'h0000_00AB);
    checkOutput("p1_mem_wea",   32'(bus.mem_wea),  32'h1);
    checkOutput("p1_count",     32'(bus.count),    32'd1);
    ack_once();
    checkOutput("p1_empty",     32'(bus.empty),    32'd1);
    checkOutput("p1_wea_idle",  32'(bus.mem_wea),  32'd0);

    // Zero-enable store is ignored; ack on an empty buffer is ignored
    push(32'h0000_0104, 32'h1111_1111, 4'b0000);
    checkOutput("wea0_count",   32'(bus.count),    32'd0);
    ack_once();
    checkOutput("ackempty_cnt", 32'(bus.count),    32'd0);

    // Fill to DEPTH, drop a fifth push, then drain in order
    for (int k = 0; k < 4; k++) push(32'h0000_0010 + 32'(4 * k), 32'(k), 4'b1111);
    checkOutput("full_ready",   32'(bus.wr_ready), 32'd0);
    checkOutput("full_count",   32'(bus.count),    32'd4);
    push(32'h0000_0999, 32'h5555_5555, 4'b1111);
    checkOutput("drop_count",   32'(bus.count),    32'd4);
    checkOutput("drop_head",    bus.mem_wdata,     32'd0);
    ack_once();
    checkOutput("pop_count",    32'(bus.count),    32'd3);
    checkOutput("pop_ready",    32'(bus.wr_ready), 32'd1);
    for (int k = 1; k < 4; k++) begin
      checkOutput($sformatf("order_data%0d", k), bus.mem_wdata, 32'(k));
      checkOutput($sformatf("order_addr%0d", k), bus.mem_addr, 32'h0000_0010 + 32'(4 * k));
      ack_once();
    end
    checkOutput("drain_empty",  32'(bus.empty),    32'd1);

    // Lane merge from two partial stores to one word
    push(32'h0000_0200, 32'h0000_1100, 4'b0010);
    push(32'h0000_0200, 32'hCC00_0000, 4'b1000);
    bus.rd_addr     = 32'h0000_0202;
    bus.rd_data_mem = 32'h1234_5678;
    #1;
    checkOutput("merge_rd",     bus.rd_data,       32'hCC34_1178);
    bus.rd_addr = 32'h0000_0204;
    #1;
    checkOutput("nomatch_rd",   bus.rd_data,       32'h1234_5678);
    ack_once();
    ack_once();

    // Youngest entry wins an overlapping lane
    push(32'h0000_0300, 32'hAAAA_AAAA, 4'b1111);
    push(32'h0000_0300, 32'h0000_00BB, 4'b0001);
    bus.rd_addr     = 32'h0000_0300;
    bus.rd_data_mem = 32'h0000_0000;
    #1;
    checkOutput("young_rd",     bus.rd_data,       32'hAAAA_AABB);

    // Same-cycle push+pop: popping entry still forwards, pushed one does not
    applyStimulus(1'b1, 32'h0000_0300, 32'h0000_00CC, 4'b0001, 1'b1);
    #1;
    checkOutput("pp_fwd_rd",    bus.rd_data,       32'hAAAA_AABB);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    checkOutput("pp_count",     32'(bus.count),    32'd2);
    checkOutput("pp_after_rd",  bus.rd_data,       32'h0000_00CC);

    // Six push/pop pairs across pointer wrap, head order checked each cycle
    for (int k = 0; k < 6; k++) begin
      applyStimulus(1'b1, 32'h0000_0400 + 32'(4 * k), 32'h0000_1000 + 32'(k), 4'b1111, 1'b1);
      #1;
      checkOutput($sformatf("wrap_head%0d", k), bus.mem_wdata, exp_head[k]);
      tick();
    end
    applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    checkOutput("wrap_count",   32'(bus.count),    32'd2);
    checkOutput("wrap_head",    bus.mem_wdata,     32'h0000_1004);

    // Reset in mid-drain discards everything
    push(32'h0000_0418, 32'h0000_1006, 4'b1111);
    checkOutput("pre_rst_cnt",  32'(bus.count),    32'd3);
    bus.rd_addr     = 32'h0000_0410;
    bus.rd_data_mem = 32'h7777_7777;
    #1;
    checkOutput("pre_rst_rd",   bus.rd_data,       32'h0000_1004);
    rst = 1'b1;
    applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
    tick();
    rst = 1'b0;
    applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    #1;
    checkOutput("post_rst_cnt", 32'(bus.count),    32'd0);
    checkOutput("post_rst_req", 32'(bus.mem_req),  32'd0);
    checkOutput("post_rst_wea", 32'(bus.mem_wea),  32'd0);
    checkOutput("post_rst_rdy", 32'(bus.wr_ready), 32'd1);
    checkOutput("post_rst_rd",  bus.rd_data,       32'h7777_7777);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dm_wbuf.md
DM_WBUF -- requirements
Module: dm_wbuf

Interface
REQ-001 SHALL have parameter: DEPTH, 4, number of buffered store entries (power of two, 2..16).
REQ-002 SHALL have port: clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port: wr_valid  input  1  store request from the byte-lane controller.
REQ-005 SHALL have port: wr_addr  input  32  store byte address; only bits [31:2] are stored.
REQ-006 SHALL have port: wr_data  input  32  lane-aligned store data.
REQ-007 SHALL have port: wr_wea  input  4  per-byte write enables, bit i = bits [8i+7:8i].
REQ-008 SHALL have port: wr_ready  output  1  buffer can accept a store this cycle.
REQ-009 SHALL have port: mem_req  output  1  head entry presented to data memory.
REQ-010 SHALL have port: mem_addr  output  32  head word address, bits [1:0] = 00.
REQ-011 SHALL have port: mem_wdata  output  32  head data.
REQ-012 SHALL have port: mem_wea  output  4  head byte enables; 0000 when mem_req = 0.
REQ-013 SHALL have port: mem_ack  input  1  memory accepted the head this cycle.
REQ-014 SHALL have port: rd_addr  input  32  load byte address for forwarding.
REQ-015 SHALL have port: rd_data_mem  input  32  raw word read from data memory at rd_addr.
REQ-016 SHALL have port: rd_data  output  32  raw word with buffered bytes merged in, sent to the byte-lane controller.
REQ-017 SHALL have port: empty  output  1  no valid entries.
REQ-018 SHALL have port: count  output  clog2(DEPTH)+1  number of valid entries.

Function
REQ-019 SHALL operate as a circular FIFO with head and tail pointers that wrap modulo DEPTH and a count in the range 0..DEPTH.
REQ-020 SHALL register a push on the clock edge when wr_valid = 1, wr_ready = 1 and wr_wea != 0; it SHALL store {wr_addr[31:2], wr_data, wr_wea} at the tail and advance the tail.
REQ-021 SHALL ignore a store with wr_wea = 0000: no entry, and no change to count.
REQ-022 SHALL drive wr_ready = (count != DEPTH) from registered state only; wr_ready SHALL NOT depend on mem_ack in the same cycle.
REQ-023 SHALL drive mem_req = !empty, and mem_addr, mem_wdata, mem_wea from the head entry combinationally.
REQ-024 SHALL pop the head on the edge where mem_req = 1 and mem_ack = 1; mem_ack SHALL be ignored when the buffer is empty.
REQ-025 SHALL, on a simultaneous push and pop, leave count unchanged and advance both pointers; this SHALL be legal only when count < DEPTH.
REQ-026 SHALL NOT coalesce entries; stores SHALL drain in strict program order, one entry per mem_ack.
REQ-027 SHALL form rd_data lane by lane: for each lane i, take lane i of the youngest valid entry whose address matches rd_addr[31:2] and whose wea[i] = 1; otherwise take lane i of rd_data_mem.
REQ-028 SHALL include the entry being popped in the current cycle in forwarding, and SHALL exclude a store being pushed in the current cycle.
REQ-029 SHALL give forwarding latency zero, with rd_data combinational from registered entries plus rd_addr and rd_data_mem.
REQ-030 SHALL drive empty = (count == 0).

Reset
REQ-031 SHALL, while rst = 1 at a clock edge, clear the head, tail and count to 0, discarding all entries including one in mid-drain.
REQ-032 SHALL, after reset, drive empty = 1, wr_ready = 1, mem_req = 0, mem_wea = 0000 and count = 0; rd_data SHALL equal rd_data_mem.
REQ-033 SHALL NOT require entry storage to be reset; stale entries SHALL never forward or drain.

Verification
REQ-034 SHALL cover: reset, then one push of addr 0x100, data 0x000000AB, wea 0001 with mem_ack = 0 -> mem_req = 1, mem_addr = 0x100, mem_wea = 0001, count = 1; then mem_ack = 1 for one cycle -> empty = 1, mem_wea = 0000.
REQ-035 SHALL cover: push DEPTH = 4 entries with mem_ack held at 0 -> wr_ready = 0 and count = 4; a fifth push is dropped; mem_ack = 1 for one cycle -> count = 3 and wr_ready = 1.
REQ-036 SHALL cover: buffer holds 0x200/0x0000_1100/wea 0010, then 0x200/0xCC00_0000/wea 1000, with rd_addr = 0x202 and rd_data_mem = 0x1234_5678 -> rd_data = 0xCC34_1178.
REQ-037 SHALL cover: two entries to 0x300, the older with wea 1111 data 0xAAAA_AAAA and the younger with wea 0001 data 0x0000_00BB, rd_data_mem = 0 -> rd_data = 0xAAAA_AABB (youngest wins lane 0).
REQ-038 SHALL cover: count = 2, push and mem_ack in the same cycle -> count stays 2, and drain order is preserved across pointer wrap-around after 6 further push/pop pairs.
REQ-039 SHALL cover: rst asserted with count = 3 and mem_ack = 1 -> next cycle count = 0, mem_req = 0, and rd_data = rd_data_mem for a previously matching rd_addr.
